inst_byte_tx: RTL and testbench

Serializes 2*BITS-bit words into BITS-bit bytes, high byte first, then low byte, over a valid/ready byte stream. It is the transmit-side counterpart of the instruction-register byte loader. It returns instruction and result words to the host-facing 8-bit port in the same hi-then-lo order the loader consumes. A small word FIFO decouples the vector core from host back-pressure.

---
 rtl/inst_byte_tx_pkg.sv | 17 +
 rtl/inst_byte_tx_if.sv | 39 +++
 rtl/inst_byte_tx_word_fifo.sv | 74 +++++++
 rtl/inst_byte_tx.sv | 113 +++++++++++
 tb/tb_inst_byte_tx.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_byte_tx_pkg.sv
// ---------------------------------------------------------------------------
// inst_tx_pkg
// Shared types and defaults for the instruction/result byte transmitter.
//   tx_state_t   : serializer FSM states
//   DEFAULT_BITS : default byte width (the word is twice this)
// ---------------------------------------------------------------------------
package inst_tx_pkg;

  localparam int DEFAULT_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_LO
  } tx_state_t;

endpackage

// File: rtl/inst_byte_tx_if.sv
// ---------------------------------------------------------------------------
// inst_byte_tx_if
// Bundles the word-in / byte-out streams of inst_byte_tx.
//   in_word/in_valid/in_ready        : word push side (vector core)
//   out_byte/out_valid/out_ready     : byte stream to the host port
//   out_is_hi                        : out_byte carries the high half
//   count                            : words waiting in the FIFO
//   busy                             : serializer is mid-word
// modport slave  : the transmitter itself
// modport master : whoever feeds words in and consumes bytes
// ---------------------------------------------------------------------------
interface inst_byte_tx_if
  import inst_tx_pkg::*;
#(
  parameter int BITS  = DEFAULT_BITS,
  parameter int DEPTH = 4
) ();

  logic [2*BITS-1:0]          in_word;
  logic                       in_valid;
  logic                       in_ready;
  logic [BITS-1:0]            out_byte;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_is_hi;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       busy;

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_byte, out_valid, out_is_hi, count, busy
  );

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_byte, out_valid, out_is_hi, count, busy
  );

endinterface

// File: rtl/inst_byte_tx_word_fifo.sv
// ---------------------------------------------------------------------------
// word_fifo
// Small synchronous FIFO with a registered head word.
//   clk, rst         : rising-edge clock, synchronous active-high reset
//   i_push, i_data   : write i_data at the tail (ignored when full)
//   i_pop            : drop the head word (ignored when empty)
//   o_head           : current head word, registered
//   o_full, o_empty  : derived from o_count
//   o_count          : number of words stored
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rdNext;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;
  assign w_rdNext = w_pop ? r_rdPtr + AW'(1) : r_rdPtr;

  assign o_head   = r_head;
  assign o_count  = r_count;

  // The head register is preloaded with whatever will sit at the read
  // pointer after this edge. If that slot is being written right now
  // (FIFO empty, or draining its last word), the incoming word is
  // forwarded since the memory does not hold it yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      r_rdPtr <= w_rdNext;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_head <= (w_push && (r_wrPtr == w_rdNext)) ? i_data : r_mem[w_rdNext];
    end
  end

endmodule

// File: rtl/inst_byte_tx.sv
// ---------------------------------------------------------------------------
// inst_byte_tx
// Serializes 2*BITS-bit words into BITS-bit bytes, high byte first, onto a
// valid/ready byte stream. A word FIFO absorbs host back-pressure.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; discards FIFO and any partial word
//   bus  : inst_byte_tx_if.slave (word input, byte output, count, busy)
// ---------------------------------------------------------------------------
module inst_byte_tx
  import inst_tx_pkg::*;
#(
  parameter int BITS  = DEFAULT_BITS,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  inst_byte_tx_if.slave  bus
);

  localparam int CW = $clog2(DEPTH+1);

  tx_state_t         r_state;
  // Only the low byte needs holding: the high byte is loaded straight into
  // the output register at pop time.
  logic [BITS-1:0]   r_hold;
  logic [BITS-1:0]   r_outByte;
  logic              r_outValid;
  logic              r_outIsHi;

  logic [2*BITS-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count;

  assign w_push = bus.in_valid && bus.in_ready;
  // Pop from IDLE, or when the low byte leaves and another word waits, so
  // consecutive words stream without a bubble.
  assign w_pop  = !w_empty &&
                  ((r_state == IDLE) || ((r_state == SEND_LO) && bus.out_ready));

  word_fifo #(
    .WIDTH (2*BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (bus.in_word),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Serializer FSM with registered outputs; outputs only change on a
  // transfer or a pop, so they hold steady under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_outByte  <= '0;
      r_outValid <= 1'b0;
      r_outIsHi  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_hold     <= w_head[BITS-1:0];
            r_outByte  <= w_head[2*BITS-1:BITS];
            r_outValid <= 1'b1;
            r_outIsHi  <= 1'b1;
            r_state    <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (bus.out_ready) begin
            r_outByte <= r_hold;
            r_outIsHi <= 1'b0;
            r_state   <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (bus.out_ready) begin
            if (w_pop) begin
              r_hold    <= w_head[BITS-1:0];
              r_outByte <= w_head[2*BITS-1:BITS];
              r_outIsHi <= 1'b1;
              r_state   <= SEND_HI;
            end else begin
              r_outByte  <= '0;
              r_outValid <= 1'b0;
              r_state    <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // in_ready is pulled low during reset so nothing is pushed into a FIFO
  // that is being cleared.
  assign bus.in_ready  = !w_full && !rst;
  assign bus.out_byte  = r_outByte;
  assign bus.out_valid = r_outValid;
  assign bus.out_is_hi = r_outIsHi;
  assign bus.count     = w_count;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_inst_byte_tx.sv
// ---------------------------------------------------------------------------
// tb_inst_byte_tx
// Self-checking bench for inst_byte_tx. The reference model is a word queue
// (FIFO contents) plus a byte queue (bytes of the word being sent).
// ---------------------------------------------------------------------------
module tb_inst_byte_tx;

  localparam int BITS  = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_byte_tx_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();

  inst_byte_tx #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  logic [15:0] mQ[$];
  logic [7:0]  mCur[$];

  task automatic applyStimulus(input logic v, input logic [15:0] w, input logic r);
    bus.in_valid  = v;
    bus.in_word   = w;
    bus.out_ready = r;
  endtask

  // One clock edge, with the model advanced by the same inputs.
  task automatic tick();
    bit accept;
    logic [15:0] wd;
    accept = bus.in_valid && !rst && (mQ.size() < DEPTH);
    @(posedge clk);
    if (rst) begin
      mQ.delete();
      mCur.delete();
    end else begin
      if (mCur.size() > 0 && bus.out_ready) void'(mCur.pop_front());
      if (mCur.size() == 0 && mQ.size() > 0) begin
        wd = mQ.pop_front();
        mCur.push_back(wd[15:8]);
        mCur.push_back(wd[7:0]);
      end
      if (accept) mQ.push_back(bus.in_word);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0);
    tick();
    tick();
    nChecks++;
    if (bus.in_ready !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    nChecks++;
    if (bus.out_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    nChecks++;
    if (bus.count !== 3'd0) begin nErrors++; $display("[TB] FAIL reset_count: got %0d want 0", bus.count); end
    nChecks++;
    if ({bus.busy, bus.out_is_hi, bus.out_byte} !== 10'h0) begin
      nErrors++; $display("[TB] FAIL reset_outputs: busy=%b hi=%b byte=%h want all 0", bus.busy, bus.out_is_hi, bus.out_byte);
    end
    rst = 1'b0;
    tick();
    nChecks++;
    if (bus.in_ready !== 1'b1) begin nErrors++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single_word();
    applyStimulus(1'b1, 16'hA55A, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0, 1'b1);
    nChecks++;
    if (bus.count !== 3'd1 || bus.out_valid !== 1'b0) begin
      nErrors++; $display("[TB] FAIL single_after_push: count=%0d valid=%b want 1/0", bus.count, bus.out_valid);
    end
    tick();
    nChecks++;
    if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'hA5 || bus.out_is_hi !== 1'b1 || bus.busy !== 1'b1) begin
      nErrors++; $display("[TB] FAIL single_hi: valid=%b byte=%h hi=%b busy=%b want 1/a5/1/1", bus.out_valid, bus.out_byte, bus.out_is_hi, bus.busy);
    end
    tick();
    nChecks++;
    if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h5A || bus.out_is_hi !== 1'b0) begin
      nErrors++; $display("[TB] FAIL single_lo: valid=%b byte=%h hi=%b want 1/5a/0", bus.out_valid, bus.out_byte, bus.out_is_hi);
    end
    tick();
    nChecks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      nErrors++; $display("[TB] FAIL single_done: busy=%b valid=%b want 0/0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    applyStimulus(1'b1, 16'h1234, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h12 || bus.out_is_hi !== 1'b1) begin
        nErrors++; $display("[TB] FAIL bp_stall%0d: valid=%b byte=%h hi=%b want 1/12/1", i, bus.out_valid, bus.out_byte, bus.out_is_hi);
      end
      tick();
    end
    applyStimulus(1'b0, 16'h0, 1'b1);
    nChecks++;
    if (bus.out_byte !== 8'h12) begin nErrors++; $display("[TB] FAIL bp_release_hi: got %h want 12", bus.out_byte); end
    tick();
    nChecks++;
    if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h34 || bus.out_is_hi !== 1'b0) begin
      nErrors++; $display("[TB] FAIL bp_release_lo: valid=%b byte=%h hi=%b want 1/34/0", bus.out_valid, bus.out_byte, bus.out_is_hi);
    end
    tick();
    nChecks++;
    if (bus.out_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL bp_idle: valid=%b want 0", bus.out_valid); end
  endtask

  task automatic test_full_fifo();
    logic [7:0] expBytes[10] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05};
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 16'(k), 1'b0);
      if (k == 6) begin
        nChecks++;
        if (bus.in_ready !== 1'b0 || bus.count !== 3'd4) begin
          nErrors++; $display("[TB] FAIL full_flags: in_ready=%b count=%0d want 0/4", bus.in_ready, bus.count);
        end
      end
      tick();
    end
    applyStimulus(1'b0, 16'h0, 1'b0);
    nChecks++;
    if (bus.count !== 3'(mQ.size())) begin nErrors++; $display("[TB] FAIL full_count: got %0d want %0d", bus.count, mQ.size()); end
    applyStimulus(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      nChecks++;
      if (bus.out_valid !== 1'b1 || bus.out_byte !== expBytes[i] || bus.out_is_hi !== ((i % 2) == 0)) begin
        nErrors++; $display("[TB] FAIL full_drain%0d: valid=%b byte=%h hi=%b want 1/%h/%b", i, bus.out_valid, bus.out_byte, bus.out_is_hi, expBytes[i], (i % 2) == 0);
      end
      tick();
    end
    nChecks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      nErrors++; $display("[TB] FAIL full_drained: valid=%b count=%0d want 0/0", bus.out_valid, bus.count);
    end
  endtask

  // Random words with random push gaps; every cycle is compared against
  // the model, and the collected byte stream against the pushed words.
  task automatic test_streaming(input bit randomReady);
    logic [15:0] words[8];
    logic [7:0]  want[$];
    logic [7:0]  seen[$];
    int sent = 0;
    int gap  = 0;
    int cyc  = 0;
    logic rdy;
    for (int i = 0; i < 8; i++) begin
      words[i] = 16'($urandom);
      want.push_back(words[i][15:8]);
      want.push_back(words[i][7:0]);
    end
    while ((sent < 8 || mQ.size() > 0 || mCur.size() > 0) && cyc < 300) begin
      rdy = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < 8 && gap == 0) begin
        applyStimulus(1'b1, words[sent], rdy);
        if (mQ.size() < DEPTH) begin
          sent++;
          gap = $urandom_range(0, 2);
        end
      end else begin
        applyStimulus(1'b0, 16'h0, rdy);
        if (gap > 0) gap--;
      end
      nChecks++;
      if (bus.out_valid !== (mCur.size() > 0) || bus.busy !== (mCur.size() > 0) ||
          bus.count !== 3'(mQ.size()) || bus.in_ready !== (mQ.size() < DEPTH)) begin
        nErrors++;
        $display("[TB] FAIL stream_status c%0d: valid=%b busy=%b count=%0d in_ready=%b want %b/%b/%0d/%b", cyc,
                 bus.out_valid, bus.busy, bus.count, bus.in_ready, mCur.size() > 0, mCur.size() > 0, mQ.size(), mQ.size() < DEPTH);
      end
      if (mCur.size() > 0) begin
        nChecks++;
        if (bus.out_byte !== mCur[0] || bus.out_is_hi !== (mCur.size() == 2)) begin
          nErrors++; $display("[TB] FAIL stream_byte c%0d: byte=%h hi=%b want %h/%b", cyc, bus.out_byte, bus.out_is_hi, mCur[0], mCur.size() == 2);
        end
      end
      if (bus.out_valid === 1'b1 && rdy) seen.push_back(bus.out_byte);
      tick();
      cyc++;
    end
    applyStimulus(1'b0, 16'h0, 1'b1);
    nChecks++;
    if (cyc >= 300) begin nErrors++; $display("[TB] FAIL stream_timeout: cycles=%0d limit=300", cyc); end
    nChecks++;
    if (seen.size() != want.size()) begin
      nErrors++; $display("[TB] FAIL stream_len: got %0d bytes want %0d", seen.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        nChecks++;
        if (seen[i] !== want[i]) begin nErrors++; $display("[TB] FAIL stream_order%0d: got %h want %h", i, seen[i], want[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'hC0DE + 16'(k), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'h0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    tick();
    nChecks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.busy !== 1'b0) begin
      nErrors++; $display("[TB] FAIL midreset_during: in_ready=%b valid=%b count=%0d busy=%b want 0/0/0/0", bus.in_ready, bus.out_valid, bus.count, bus.busy);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      nChecks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        nErrors++; $display("[TB] FAIL midreset_quiet%0d: valid=%b in_ready=%b want 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
    applyStimulus(1'b1, 16'hBEEF, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0, 1'b1);
    tick();
    nChecks++;
    if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'hBE || bus.out_is_hi !== 1'b1) begin
      nErrors++; $display("[TB] FAIL midreset_new_hi: valid=%b byte=%h hi=%b want 1/be/1", bus.out_valid, bus.out_byte, bus.out_is_hi);
    end
    tick();
    nChecks++;
    if (bus.out_byte !== 8'hEF || bus.out_is_hi !== 1'b0) begin
      nErrors++; $display("[TB] FAIL midreset_new_lo: byte=%h hi=%b want ef/0", bus.out_byte, bus.out_is_hi);
    end
    tick();
  endtask

  initial begin
    applyStimulus(1'b0, 16'h0, 1'b0);
    test_reset();
    test_single_word();
    test_backpressure();
    test_full_fifo();
    test_streaming(1'b0);
    test_streaming(1'b1);
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
